// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for the multicycle RV32I core. It walks each instruction through
//   fetch / decode / execute / writeback and drives the ALU control and operand selects,
//   the memory and register-file strobes, and the PC/IR enables.
//
// Ports
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   op, funct3,         instruction fields [6:0], [14:12], [30]
//   funct7b5
//   zero                ALU zero flag (branch condition)
//   PC_write            PC enable (update | taken branch)
//   address_source      memory address: 0 = PC, 1 = result
//   memory_write        data memory write enable
//   IR_write            instruction register / old_PC enable
//   result_source       00 ALU_out, 01 read data, 10 ALU_result
//   ALU_control         000 add, 001 sub, 010 and, 011 or, 101 slt
//   ALU_src_A           00 PC, 01 old_PC, 10 rd1
//   ALU_src_B           00 rd2, 01 immediate, 10 constant 4
//   register_write      register file write enable
//   immediate_source    00 I, 01 S, 10 B, 11 J
//
// Build option
//   MULTICYCLE_CONTROLLER_BNE_EN  when defined, the branch state also executes bne
//                                 (funct3[0] inverts the zero condition).

module multicycle_controller (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PC_write,
  output logic       address_source,
  output logic       memory_write,
  output logic       IR_write,
  output logic [1:0] result_source,
  output logic [2:0] ALU_control,
  output logic [1:0] ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic       register_write,
  output logic [1:0] immediate_source
);

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StJal      = 4'd9;
  localparam logic [3:0] StBeq      = 4'd10;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic [3:0] state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       branch_taken;

  // Reset is asynchronous so write strobes drop the moment reset_n falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpJal:           state_d = StJal;
          OpBranch:        state_d = StBeq;
          default:         state_d = StFetch;  // unsupported op runs as a nop
        endcase
      end
      StMemAdr:  state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: state_d = StMemWb;
      StExecR:   state_d = StAluWb;
      StExecI:   state_d = StAluWb;
      StJal:     state_d = StAluWb;
      default:   state_d = StFetch;  // writeback states, branch and unused encodings
    endcase
  end

  // State output decode (Moore part).
  always_comb begin
    pc_update      = 1'b0;
    branch         = 1'b0;
    address_source = 1'b0;
    memory_write   = 1'b0;
    IR_write       = 1'b0;
    register_write = 1'b0;
    result_source  = 2'b00;
    ALU_src_A      = 2'b00;
    ALU_src_B      = 2'b00;
    alu_op         = 2'b00;
    case (state_q)
      StFetch: begin
        IR_write      = 1'b1;
        ALU_src_B     = 2'b10;
        result_source = 2'b10;
        pc_update     = 1'b1;
      end
      StDecode: begin
        // Precompute the branch/jump target into ALU_out.
        ALU_src_A = 2'b01;
        ALU_src_B = 2'b01;
      end
      StMemAdr: begin
        ALU_src_A = 2'b10;
        ALU_src_B = 2'b01;
      end
      StMemRead: begin
        address_source = 1'b1;
      end
      StMemWb: begin
        result_source  = 2'b01;
        register_write = 1'b1;
      end
      StMemWrite: begin
        address_source = 1'b1;
        memory_write   = 1'b1;
      end
      StExecR: begin
        ALU_src_A = 2'b10;
        alu_op    = 2'b10;
      end
      StExecI: begin
        ALU_src_A = 2'b10;
        ALU_src_B = 2'b01;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        register_write = 1'b1;
      end
      StJal: begin
        ALU_src_A = 2'b01;
        ALU_src_B = 2'b10;
        pc_update = 1'b1;
      end
      StBeq: begin
        ALU_src_A = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULTICYCLE_CONTROLLER_BNE_EN
  assign branch_taken = zero ^ funct3[0];
`else
  assign branch_taken = zero;
`endif

  // Only Mealy path: a taken branch loads the target held in ALU_out.
  assign PC_write = pc_update | (branch & branch_taken);

  // ALU decoder.
  always_comb begin
    ALU_control = 3'b000;
    case (alu_op)
      2'b00: ALU_control = 3'b000;
      2'b01: ALU_control = 3'b001;
      default: begin
        case (funct3)
          // op[5] separates R-type sub from addi whose imm[10] lands on funct7b5.
          3'b000:  ALU_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALU_control = 3'b101;
          3'b110:  ALU_control = 3'b011;
          3'b111:  ALU_control = 3'b010;
          default: ALU_control = 3'b000;
        endcase
      end
    endcase
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    immediate_source = 2'b00;
    case (op)
      OpStore:  immediate_source = 2'b01;
      OpBranch: immediate_source = 2'b10;
      OpJal:    immediate_source = 2'b11;
      default:  immediate_source = 2'b00;
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32I core. Sits directly upstream of the ALU: it decodes op/funct3/funct7b5 and drives ALU_control and the operand selects in front of src_A/src_B. It consumes the ALU's zero flag for branches, and it sequences PC, IR, memory and register-file writes.

Parameters:
(none; widths are fixed by the RV32I encoding)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
op  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
funct7b5  in  1  instruction[30]
zero  in  1  ALU zero flag
PC_write  out  1  PC register enable
address_source  out  1  memory address select: 0 = PC, 1 = result
memory_write  out  1  data memory write enable
IR_write  out  1  instruction register enable (also latches old_PC)
result_source  out  2  00 = ALU_out reg, 01 = read data, 10 = ALU_result direct
ALU_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ALU_src_A  out  2  00 = PC, 01 = old_PC, 10 = rd1
ALU_src_B  out  2  00 = rd2, 01 = immediate, 10 = constant 4
register_write  out  1  register file write enable
immediate_source  out  2  00 = I, 01 = S, 10 = B, 11 = J

Behaviour:
- Single 4-bit state register. Clock and reset are fixed: one clock, asynchronous active-low reset.
- Reset (reset_n = 0): state := FETCH immediately, without waiting for a clock edge.
- All outputs are combinational decodes of the state register, so during reset they show FETCH values.
- Reset asserted mid-instruction aborts the instruction; no write strobe may stay high after reset asserts.
- Every output not listed for a state below is 0.
- PC_write = PC_update | (branch & zero). The branch term is the only Mealy path.
- States, their outputs, and the next state:
- FETCH: IR_write=1, src_A=00, src_B=10, ALUOp=00, result_source=10, PC_update=1. Next: DECODE.
- DECODE: src_A=01, src_B=01, ALUOp=00 (branch/jump target into ALU_out). Next, by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTE_R
  - 0010011 -> EXECUTE_I
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> FETCH (executes as a nop)
- MEMADR: src_A=10, src_B=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: address_source=1, result_source=00. Next: MEMWB.
- MEMWB: result_source=01, register_write=1. Next: FETCH.
- MEMWRITE: address_source=1, result_source=00, memory_write=1. Next: FETCH.
- EXECUTE_R: src_A=10, src_B=00, ALUOp=10. Next: ALUWB.
- EXECUTE_I: src_A=10, src_B=01, ALUOp=10. Next: ALUWB.
- ALUWB: result_source=00, register_write=1. Next: FETCH.
- JAL: src_A=01, src_B=10, ALUOp=00, result_source=00, PC_update=1. Next: ALUWB.
- BEQ: src_A=10, src_B=00, ALUOp=01, result_source=00, branch=1. Next: FETCH.
- Instruction latency in cycles:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
- ALU decoder (combinational, internal ALUOp):
  - ALUOp=00 -> 000 (add)
  - ALUOp=01 -> 001 (sub)
  - ALUOp=10, by funct3:
    - 000 -> 001 if (op[5] & funct7b5), else 000; so addi with imm[10] set stays add
    - 010 -> 101 (slt)
    - 110 -> 011 (or)
    - 111 -> 010 (and)
    - any other funct3 -> 000
- immediate_source is decoded from op in every state:
  - 0000011 and 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else -> 00
- memory_write and register_write are never high in the same cycle.
- IR_write is high only in FETCH.

Optional Feature:
Macro: MULTICYCLE_CONTROLLER_BNE_EN.
- Defined: BEQ state also handles funct3=001 (bne). branch_taken = zero ^ funct3[0], and PC_write = PC_update | (branch & branch_taken).
- Undefined: BEQ state ignores funct3 and uses branch & zero.

Test Plan:
- reset_n low mid-MEMWRITE, then high -> memory_write drops to 0 asynchronously; state is FETCH with IR_write=1, ALU_control=000, src_B=10.
- op=0000011 (lw) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; register_write=1 only in cycle 5 with result_source=01; then back in FETCH.
- op=0110011, funct3=000, funct7b5=1 (sub) -> ALU_control=001 in EXECUTE_R; same with op=0010011 (addi, imm bit set) -> ALU_control=000.
- op=0110011, funct3=010 / 110 / 111 -> ALU_control=101 / 011 / 010 in EXECUTE_R.
- op=1100011 (beq), zero=1 -> PC_write=1 in cycle 3; zero=0 -> PC_write=0; 3 cycles either way.
- With MULTICYCLE_CONTROLLER_BNE_EN: funct3=001, zero=0 -> PC_write=1; zero=1 -> PC_write=0. Without the macro: the same stimulus follows beq behaviour.
